// File: rtl/mips_bus_arbiter.sv
// Two-requester (fetch I / data D) Avalon-MM arbiter with per-transfer timeout watchdog.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed D>I).
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_READDATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  grant,
    output logic        bus_error
);

    localparam logic [15:0] TMO = TIMEOUT_CYCLES[15:0];

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        TURN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] timer;
    logic        op_read;
    logic        i_req;
    logic        d_req;
    logic        pick_d;
    logic        granted;
    logic        done;
    logic        abort;
    logic        finish;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign granted = (state == GRANT_I) || (state == GRANT_D);
    assign done    = granted && (read || write) && !waitrequest;
    // The bus strobe is dropped one cycle early, so the abort cycle sees timer==TMO.
    assign abort   = granted && (timer == TMO) && !done;
    assign finish  = done || abort;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;   // 0 = I, 1 = D

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= 1'b0;
        end else if (finish) begin
            last_owner <= (state == GRANT_D);
        end
    end

    assign pick_d = d_req && (!i_req || !last_owner);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = '0;
        d_readdata    = '0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nx = pick_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                if (finish) begin
                    state_nx      = TURN;
                    i_waitrequest = 1'b0;
                    i_readdata    = abort ? ERR_READDATA : readdata;
                end
            end
            GRANT_D: begin
                if (finish) begin
                    state_nx      = TURN;
                    d_waitrequest = 1'b0;
                    if (op_read) begin
                        d_readdata = abort ? ERR_READDATA : readdata;
                    end
                end
            end
            TURN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            grant      <= '0;
            timer      <= '0;
            op_read    <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        timer <= '0;
                        if (pick_d) begin
                            grant      <= 2'b10;
                            address    <= d_address;
                            writedata  <= d_writedata;
                            byteenable <= d_byteenable;
                            write      <= d_write;
                            read       <= d_read & ~d_write;
                            op_read    <= d_read & ~d_write;
                            if (d_read && d_write) begin
                                bus_error <= 1'b1;
                            end
                        end else begin
                            grant      <= 2'b01;
                            address    <= i_address;
                            writedata  <= '0;
                            byteenable <= '1;
                            write      <= 1'b0;
                            read       <= 1'b1;
                            op_read    <= 1'b1;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (finish) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        grant <= '0;
                        if (abort) begin
                            bus_error <= 1'b1;
                        end
                    end else if (waitrequest && (timer != TMO)) begin
                        timer <= timer + 16'd1;
                        if ((timer + 16'd1) == TMO) begin
                            read  <= 1'b0;
                            write <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
